// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter for the register file: round-robin req0/req1 onto the single write port, plus a pending-write scoreboard.
// Latency: grant in cycle N, rf_wen/rf_waddr/rf_wdata registered in N+1, busy clears for N+2 (N+1 with bypass).
// Backpressure: reqN_ready is the combinational grant (0 in reset); issue_ready drops while the destination is still pending.
// Optional feature: define RF_WB_BYPASS_EN to forward the in-flight write-back to the hazard queries and to issue.
module rf_wb_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  issue_valid,
   input  logic [ADDR_WIDTH-1:0] issue_addr,
   output logic                  issue_ready,
   input  logic                  req0_valid,
   input  logic [ADDR_WIDTH-1:0] req0_addr,
   input  logic [DATA_WIDTH-1:0] req0_data,
   output logic                  req0_ready,
   input  logic                  req1_valid,
   input  logic [ADDR_WIDTH-1:0] req1_addr,
   input  logic [DATA_WIDTH-1:0] req1_data,
   output logic                  req1_ready,
   output logic                  rf_wen,
   output logic [ADDR_WIDTH-1:0] rf_waddr,
   output logic [DATA_WIDTH-1:0] rf_wdata,
   input  logic [ADDR_WIDTH-1:0] qaddr1,
   input  logic [ADDR_WIDTH-1:0] qaddr2,
   output logic                  busy1,
   output logic                  busy2,
   output logic                  fwd1_valid,
   output logic                  fwd2_valid,
   output logic [DATA_WIDTH-1:0] fwd1_data,
   output logic [DATA_WIDTH-1:0] fwd2_data
);

   localparam int NREG = 1 << ADDR_WIDTH;

   // Round-robin pointer: which requester won the most recent grant.
   typedef enum logic {LAST_REQ0 = 1'b0, LAST_REQ1 = 1'b1} last_t;

   last_t                 last_q, last_d;
   logic [NREG-1:0]       busy_vec, busy_nxt;
   logic                  grant0, grant1, any_grant;
   logic [ADDR_WIDTH-1:0] gnt_addr;
   logic [DATA_WIDTH-1:0] gnt_data;
   logic                  issue_fire;
   logic                  issue_wb_hit, q1_hit, q2_hit;

`ifdef RF_WB_BYPASS_EN
   // The register being written this cycle is effectively no longer pending.
   assign issue_wb_hit = rf_wen && (issue_addr == rf_waddr);
   assign q1_hit       = rf_wen && (rf_waddr == qaddr1) && (qaddr1 != '0);
   assign q2_hit       = rf_wen && (rf_waddr == qaddr2) && (qaddr2 != '0);
`else
   assign issue_wb_hit = 1'b0;
   assign q1_hit       = 1'b0;
   assign q2_hit       = 1'b0;
`endif

   // Arbitration: single grant per cycle, tie goes to the requester not granted last.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      last_d = last_q;
      if (resetn) begin
         if (req0_valid && req1_valid) begin
            if (last_q == LAST_REQ1) grant0 = 1'b1;
            else                     grant1 = 1'b1;
         end else if (req0_valid) begin
            grant0 = 1'b1;
         end else if (req1_valid) begin
            grant1 = 1'b1;
         end
      end
      if (grant0) last_d = LAST_REQ0;
      if (grant1) last_d = LAST_REQ1;
   end

   assign any_grant  = grant0 || grant1;
   assign gnt_addr   = grant1 ? req1_addr : req0_addr;
   assign gnt_data   = grant1 ? req1_data : req0_data;
   assign req0_ready = grant0;
   assign req1_ready = grant1;

   assign issue_ready = resetn && ((issue_addr == '0) || !busy_vec[issue_addr] || issue_wb_hit);
   assign issue_fire  = issue_valid && issue_ready && (issue_addr != '0);

   // Scoreboard update: clear on the write edge, then set from issue so set wins on a collision.
   always_comb begin
      busy_nxt = busy_vec;
      if (rf_wen)     busy_nxt[rf_waddr]   = 1'b0;
      if (issue_fire) busy_nxt[issue_addr] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   assign busy1      = (qaddr1 != '0) && busy_vec[qaddr1] && !q1_hit;
   assign busy2      = (qaddr2 != '0) && busy_vec[qaddr2] && !q2_hit;
   assign fwd1_valid = q1_hit;
   assign fwd2_valid = q2_hit;
   assign fwd1_data  = q1_hit ? rf_wdata : '0;
   assign fwd2_data  = q2_hit ? rf_wdata : '0;

   // State and write-port register; address/data hold when nothing is granted.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         busy_vec <= '0;
         last_q   <= LAST_REQ1;
         rf_wen   <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else begin
         busy_vec <= busy_nxt;
         last_q   <= last_d;
         rf_wen   <= any_grant && (gnt_addr != '0);
         if (any_grant) begin
            rf_waddr <= gnt_addr;
            rf_wdata <= gnt_data;
         end
      end
   end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed test-plan scenarios then randomized traffic,
// every cycle compared against a behavioural scoreboard/round-robin model.
// Expectations follow RF_WB_BYPASS_EN when it is defined for the build.
module tb_rf_wb_arbiter;

   localparam int DW = 32;
   localparam int AW = 5;
`ifdef RF_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          resetn;
   logic          issue_valid, issue_ready;
   logic [AW-1:0] issue_addr;
   logic          req0_valid, req0_ready, req1_valid, req1_ready;
   logic [AW-1:0] req0_addr, req1_addr;
   logic [DW-1:0] req0_data, req1_data;
   logic          rf_wen;
   logic [AW-1:0] rf_waddr;
   logic [DW-1:0] rf_wdata;
   logic [AW-1:0] qaddr1, qaddr2;
   logic          busy1, busy2, fwd1_valid, fwd2_valid;
   logic [DW-1:0] fwd1_data, fwd2_data;

   always #5 clk = ~clk;

   rf_wb_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .resetn(resetn),
      .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_ready(issue_ready),
      .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
      .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .qaddr1(qaddr1), .qaddr2(qaddr2),
      .busy1(busy1), .busy2(busy2),
      .fwd1_valid(fwd1_valid), .fwd2_valid(fwd2_valid),
      .fwd1_data(fwd1_data), .fwd2_data(fwd2_data)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, obs, exp);
      end
   endtask

   // Reference model: set of pending registers, who was granted last, and the write in flight.
   logic [31:0]   m_pending;
   int            m_last;       // 0 or 1
   bit            m_wen;
   logic [AW-1:0] m_waddr;
   logic [DW-1:0] m_wdata;
   logic [31:0]   n_pending;
   int            n_last;
   bit            n_wen;
   logic [AW-1:0] n_waddr;
   logic [DW-1:0] n_wdata;
   bit            e_g0, e_g1;
   int            wait0, wait1;

   function automatic bit pend(input logic [AW-1:0] a);
      return (a != 0) && m_pending[a] && !(BYP && m_wen && m_waddr == a);
   endfunction

   // Settle the inputs, compare every output with the model and compute the model's next state.
   task automatic settle();
      bit ir, f1, f2;
      #1;
      ir = resetn && (issue_addr == 0 || !m_pending[issue_addr] || (BYP && m_wen && m_waddr == issue_addr));
      e_g0 = 1'b0; e_g1 = 1'b0;
      if (resetn) begin
         if (req0_valid && req1_valid) begin
            if (m_last == 1) e_g0 = 1'b1; else e_g1 = 1'b1;
         end else begin
            e_g0 = req0_valid;
            e_g1 = req1_valid;
         end
      end
      f1 = BYP && m_wen && m_waddr == qaddr1 && qaddr1 != 0;
      f2 = BYP && m_wen && m_waddr == qaddr2 && qaddr2 != 0;
      check("issue_ready", issue_ready, ir);
      check("req0_ready", req0_ready, e_g0);
      check("req1_ready", req1_ready, e_g1);
      check("rf_wen", rf_wen, m_wen);
      check("rf_waddr", rf_waddr, m_waddr);
      check("rf_wdata", rf_wdata, m_wdata);
      check("busy1", busy1, pend(qaddr1));
      check("busy2", busy2, pend(qaddr2));
      check("fwd1_valid", fwd1_valid, f1);
      check("fwd2_valid", fwd2_valid, f2);
      check("fwd1_data", fwd1_data, f1 ? m_wdata : 32'h0);
      check("fwd2_data", fwd2_data, f2 ? m_wdata : 32'h0);
      // Fairness: a valid requester never waits more than one cycle.
      if (resetn) begin
         wait0 = (req0_valid && !req0_ready) ? wait0 + 1 : 0;
         wait1 = (req1_valid && !req1_ready) ? wait1 + 1 : 0;
         check("wait_ok", (wait0 <= 1 && wait1 <= 1), 1);
      end else begin
         wait0 = 0; wait1 = 0;
      end
      if (!resetn) begin
         n_pending = '0; n_last = 1; n_wen = 1'b0; n_waddr = '0; n_wdata = '0;
      end else begin
         n_pending = m_pending;
         if (m_wen) n_pending[m_waddr] = 1'b0;
         if (issue_valid && ir && issue_addr != 0) n_pending[issue_addr] = 1'b1;
         n_last = m_last; n_wen = 1'b0; n_waddr = m_waddr; n_wdata = m_wdata;
         if (e_g0) begin n_last = 0; n_wen = (req0_addr != 0); n_waddr = req0_addr; n_wdata = req0_data; end
         if (e_g1) begin n_last = 1; n_wen = (req1_addr != 0); n_waddr = req1_addr; n_wdata = req1_data; end
      end
   endtask

   task automatic advance();
      @(posedge clk);
      m_pending = n_pending; m_last = n_last; m_wen = n_wen; m_waddr = n_waddr; m_wdata = n_wdata;
      @(negedge clk);
   endtask

   task automatic step();
      settle();
      advance();
   endtask

   task automatic idle();
      issue_valid = 0; req0_valid = 0; req1_valid = 0;
   endtask

   initial begin
      logic [AW-1:0] order_addr [4];
      int            gseq [$];
      m_pending = '0; m_last = 1; m_wen = 0; m_waddr = '0; m_wdata = '0;
      wait0 = 0; wait1 = 0;
      resetn = 0; idle();
      issue_addr = '0; req0_addr = '0; req1_addr = '0; req0_data = '0; req1_data = '0;
      qaddr1 = '0; qaddr2 = '0;
      @(negedge clk);
      step(); step();

      // Reset state, then issue r5 and write it back through req0.
      resetn = 1;
      settle();
      check("rst_rf_wen", rf_wen, 0);
      check("rst_rf_waddr", rf_waddr, 0);
      advance();
      issue_valid = 1; issue_addr = 5; qaddr1 = 5;
      step();
      idle();
      req0_valid = 1; req0_addr = 5; req0_data = 32'h1234;
      settle();
      check("r5_grant", req0_ready, 1);
      check("r5_busy_N", busy1, 1);
      advance();
      idle();
      settle();
      check("r5_wen", rf_wen, 1);
      check("r5_waddr", rf_waddr, 5);
      check("r5_wdata", rf_wdata, 32'h1234);
      check("r5_fwd", fwd1_valid, BYP);
      advance();
      settle();
      check("r5_busy_N2", busy1, 0);
      advance();

      // Both requesters valid with r1..r4: grants alternate starting at req0 after reset.
      resetn = 0; step(); resetn = 1;
      order_addr[0] = 1; order_addr[1] = 3; order_addr[2] = 2; order_addr[3] = 4;
      begin
         int i0 = 0, i1 = 0;
         for (int c = 0; c < 4; c++) begin
            req0_valid = (i0 < 2); req0_addr = order_addr[i0 % 2 * 1 + 0 + (i0 < 2 ? i0 : 0) - (i0 % 2)];
            req0_addr = (i0 == 0) ? 5'd1 : 5'd3; req0_data = 32'h100 + 32'(req0_addr);
            req1_valid = (i1 < 2);
            req1_addr = (i1 == 0) ? 5'd2 : 5'd4; req1_data = 32'h100 + 32'(req1_addr);
            settle();
            if (req0_ready) begin gseq.push_back(0); i0++; end
            if (req1_ready) begin gseq.push_back(1); i1++; end
            advance();
            if (c > 0) check("rr_waddr", rf_waddr, c + 1);
         end
         idle();
         settle();
         check("rr_waddr_last", rf_waddr, 4);
         advance();
      end
      check("rr_count", gseq.size(), 4);
      for (int k = 0; k < gseq.size(); k++) check("rr_order", gseq[k], k % 2);

      // Double issue of r7, then issue of r0.
      issue_valid = 1; issue_addr = 7; qaddr2 = 7;
      settle(); check("r7_first", issue_ready, 1); advance();
      settle(); check("r7_second", issue_ready, 0); advance();
      issue_addr = 0; qaddr1 = 0;
      settle(); check("r0_issue", issue_ready, 1); advance();
      idle();
      settle(); check("r0_busy", busy1, 0); advance();

      // Write-back to r0: handshake completes, no register-file write.
      req1_valid = 1; req1_addr = 0; req1_data = 32'hFFFF_FFFF;
      settle(); check("r0_wb_ready", req1_ready, 1); advance();
      idle();
      settle(); check("r0_wb_wen", rf_wen, 0); check("r0_wb_r7", busy2, 1); advance();

      // Reset in the cycle after a grant discards the pending write and the scoreboard.
      issue_valid = 1; issue_addr = 9; qaddr1 = 9; step();
      idle();
      req0_valid = 1; req0_addr = 9; req0_data = 32'hABCD;
      step();
      idle(); resetn = 0;
      settle();
      check("rst_issue_rdy", issue_ready, 0);
      check("rst_req0_rdy", req0_ready, 0);
      advance();
      resetn = 1;
      settle();
      check("rst_wen_after", rf_wen, 0);
      check("rst_busy9", busy1, 0);
      check("rst_busy7", busy2, 0);
      advance();

      // Issue r3 in the same cycle the write-back of r3 is on the write port.
      issue_valid = 1; issue_addr = 3; qaddr1 = 3; step();
      idle(); req0_valid = 1; req0_addr = 3; req0_data = 32'h33; step();
      idle(); issue_valid = 1; issue_addr = 3;
      settle(); check("r3_coll_issue", issue_ready, BYP); advance();
      idle();
      settle(); check("r3_after", busy1, BYP); advance();

      // Randomized traffic with protocol-respecting requesters.
      for (int c = 0; c < 3000; c++) begin
         resetn = ($urandom_range(0, 79) != 0);
         issue_valid = $urandom_range(0, 1);
         issue_addr = AW'($urandom_range(0, 11));
         if (!req0_valid || e_g0) begin
            req0_valid = ($urandom_range(0, 3) != 0);
            req0_addr = AW'($urandom_range(0, 11)); req0_data = $urandom;
         end
         if (!req1_valid || e_g1) begin
            req1_valid = ($urandom_range(0, 3) != 0);
            req1_addr = AW'($urandom_range(0, 11)); req1_data = $urandom;
         end
         qaddr1 = ($urandom_range(0, 2) == 0) ? m_waddr : AW'($urandom_range(0, 11));
         qaddr2 = AW'($urandom_range(0, 31));
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
